// File: rtl/cpu_run_ctrl_if.sv
// Debug register-read channel between a debug requester (SSD display, trace dump)
// and the cpu_run_ctrl run-control sequencer.
interface cpu_run_ctrl_if;
  logic        dbg_rd_req;
  logic [4:0]  dbg_rd_idx;
  logic        dbg_rd_valid;
  logic [31:0] dbg_rd_data;

  modport master (
    output dbg_rd_req,
    output dbg_rd_idx,
    input  dbg_rd_valid,
    input  dbg_rd_data
  );

  modport slave (
    input  dbg_rd_req,
    input  dbg_rd_idx,
    output dbg_rd_valid,
    output dbg_rd_data
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer (halt / free-run / single-step / PC breakpoint) that gates the
// pipeline and lends register-file read port 1 to a debug requester while halted.
// Breakpoint logic is compiled in only when CPU_RUN_CTRL_BP_EN is defined.
module cpu_run_ctrl #(
  parameter int STEP_CYCLES = 1,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             bp_valid,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc_if,
  output logic             cpu_en,
  output logic             halted,
  output logic             step_done,
  output logic             bp_hit,
  output logic [CNT_W-1:0] cycle_cnt,
  cpu_run_ctrl_if.slave    dbg,
  output logic             rf_dbg_sel,
  output logic [4:0]       rf_rd_idx,
  input  logic [31:0]      rf_rd_data
);

  typedef enum logic [1:0] {
    HALT = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic             step_req_q;
  logic [7:0]       step_cnt_q, step_cnt_d;
  logic             step_done_q, step_done_d;
  logic             bp_hit_q, bp_hit_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic             rd_pend_q, rd_pend_d;
  logic             rd_valid_q, rd_valid_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic [4:0]       rd_idx_q, rd_idx_d;
  logic             step_edge;
  logic             bp_match;
  logic             rd_accept;

`ifdef CPU_RUN_CTRL_BP_EN
  logic        bp_armed_q, bp_armed_d;
  logic [31:0] bp_addr_q;

  assign bp_match = bp_valid & bp_armed_q & (pc_if == bp_addr);

  // Disarm on a hit so a resume can move the held instruction past bp_addr.
  always_comb begin
    bp_armed_d = bp_armed_q;
    if (cpu_en || (bp_addr != bp_addr_q)) bp_armed_d = 1'b1;
    if (bp_hit_d) bp_armed_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bp_armed_q <= 1'b1;
      bp_addr_q  <= '0;
    end else begin
      bp_armed_q <= bp_armed_d;
      bp_addr_q  <= bp_addr;
    end
  end
`else
  logic unused_bp;
  assign unused_bp = ^{bp_valid, bp_addr, pc_if};
  assign bp_match  = 1'b0;
`endif

  assign step_edge = step_req & ~step_req_q;
  assign halted    = (state_q == HALT);
  assign rd_accept = halted & dbg.dbg_rd_req & ~rd_pend_q;

  always_comb begin
    cpu_en = 1'b0;
    case (state_q)
      RUN:     cpu_en = ~halt_req & ~bp_match;
      STEP:    cpu_en = ~halt_req;
      default: cpu_en = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    step_cnt_d  = step_cnt_q;
    step_done_d = 1'b0;
    bp_hit_d    = 1'b0;
    case (state_q)
      HALT: begin
        if (!halt_req) begin
          if (step_edge) begin
            state_d    = STEP;
            step_cnt_d = 8'(STEP_CYCLES);
          end else if (run_req) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (halt_req) begin
          state_d = HALT;
        end else if (bp_match) begin
          state_d  = HALT;
          bp_hit_d = 1'b1;
        end else if (!run_req) begin
          state_d = HALT;
        end
      end
      STEP: begin
        step_cnt_d = step_cnt_q - 8'd1;
        if (halt_req) begin
          state_d    = HALT;
          step_cnt_d = '0;
        end else if (step_cnt_q == 8'd1) begin
          state_d     = HALT;
          step_done_d = 1'b1;
        end
      end
      default: state_d = HALT;
    endcase

    cycle_cnt_d = cycle_cnt_q + CNT_W'(cpu_en);

    // A pending read completes only if the port is still ours; leaving HALT cancels it.
    rd_pend_d  = rd_accept;
    rd_valid_d = rd_pend_q & halted;
    rd_idx_d   = rd_accept ? dbg.dbg_rd_idx : rd_idx_q;
    rd_data_d  = (rd_pend_q & halted) ? rf_rd_data : rd_data_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= HALT;
      step_req_q  <= 1'b0;
      step_cnt_q  <= '0;
      step_done_q <= 1'b0;
      bp_hit_q    <= 1'b0;
      cycle_cnt_q <= '0;
      rd_pend_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      step_req_q  <= step_req;
      step_cnt_q  <= step_cnt_d;
      step_done_q <= step_done_d;
      bp_hit_q    <= bp_hit_d;
      cycle_cnt_q <= cycle_cnt_d;
      rd_pend_q   <= rd_pend_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      rd_idx_q    <= rd_idx_d;
    end
  end

  assign step_done        = step_done_q;
  assign bp_hit           = bp_hit_q;
  assign cycle_cnt        = cycle_cnt_q;
  assign rf_dbg_sel       = halted;
  assign rf_rd_idx        = rd_idx_q;
  assign dbg.dbg_rd_valid = rd_valid_q;
  assign dbg.dbg_rd_data  = rd_data_q;

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run-control sequencer for the Lab5 pipelined RISC-V core. It produces the single pipeline-advance enable (`cpu_en`) that gates PC, pipeline registers and the register-file write. It implements halt, free-run, single-step and a PC breakpoint. While the core is halted, it shares register-file read port 1 with a debug requester such as the SSD `reg_index` display or a trace dump. It sits in `top` between board-level controls and the PC, pipeline and register-file blocks.

## Interface
Parameters:
- `STEP_CYCLES`, 1: clock cycles of `cpu_en` per single-step (1..255).
- `CNT_W`, 32: width of the advanced-cycle counter.

Ports:
- `clk` in 1: core clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-low.
- `run_req` in 1: level; 1 requests free-run.
- `halt_req` in 1: level; forces halt, highest priority after reset.
- `step_req` in 1: rising edge requests one step.
- `bp_valid` in 1: breakpoint enable.
- `bp_addr` in 32: breakpoint PC.
- `pc_if` in 32: PC currently in IF.
- `cpu_en` out 1: pipeline advance enable (combinational from state and inputs).
- `halted` out 1: state == HALT.
- `step_done` out 1: one-cycle pulse when a step completes.
- `bp_hit` out 1: one-cycle pulse when a breakpoint halts the core.
- `cycle_cnt` out `CNT_W`: number of cycles with `cpu_en`=1.
- `dbg_rd_req` in 1: level; debug register-read request.
- `dbg_rd_idx` in 5: register to read.
- `dbg_rd_valid` out 1: one-cycle pulse; `dbg_rd_data` valid.
- `dbg_rd_data` out 32: captured register value.
- `rf_dbg_sel` out 1: 1 = register-file read port 1 address comes from `rf_rd_idx`.
- `rf_rd_idx` out 5: debug read address.
- `rf_rd_data` in 32: register-file read port 1 data (combinational read).

## Operation
FSM states: HALT=2'b00 (reset), RUN=2'b01, STEP=2'b10.
- HALT:
  - `step_req` edge → STEP, with step counter loaded to `STEP_CYCLES`.
  - Otherwise `run_req`=1 and `halt_req`=0 → RUN.
  - A step edge wins over `run_req` in the same cycle.
- RUN:
  - `cpu_en` = ~`halt_req` & ~`bp_match`.
  - `halt_req`=1 or `run_req`=0 → HALT.
  - `bp_match` → HALT and `bp_hit` pulse.
  - `bp_match` = `bp_valid` & `bp_armed` & (`pc_if`==`bp_addr`). The instruction at `bp_addr` stays in IF and is not advanced.
- STEP:
  - `cpu_en`=1 unless `halt_req`; breakpoints are ignored.
  - Counter decrements each cycle. On the cycle it equals 1 → HALT, with `step_done` pulsed the following cycle.
  - `halt_req` aborts to HALT immediately; no `step_done`.
- `bp_armed`:
  - Cleared on `bp_hit`.
  - Set again after the first cycle with `cpu_en`=1, so a resume from a breakpoint proceeds past `bp_addr`.
  - Also set when `bp_addr` changes.
- `step_req` edge detection uses a registered copy of `step_req`.
- `cycle_cnt` increments modulo 2^`CNT_W` on every cycle with `cpu_en`=1. It wraps silently and is cleared only by reset.
- Debug read:
  - `rf_dbg_sel` = `halted`.
  - A request is accepted when `halted`=1, `dbg_rd_req`=1 and no read is pending. On acceptance `rf_rd_idx` latches `dbg_rd_idx`.
  - Next cycle: `dbg_rd_data` ← `rf_rd_data`, `dbg_rd_valid`=1.
  - A request that is still high after valid is re-accepted, giving one read per 2 cycles.
  - Requests while not halted wait; they are not dropped.
  - If HALT is left while a read is pending, the read is cancelled and no valid is produced.

## Timing
- Reset values:
  - state HALT, `halted`=1, `cpu_en`=0.
  - `step_done`=0, `bp_hit`=0, `cycle_cnt`=0.
  - `dbg_rd_valid`=0, `dbg_rd_data`=0, `rf_rd_idx`=0, `rf_dbg_sel`=1.
  - `bp_armed`=1, step counter 0.
- Reset asserted mid-RUN or mid-STEP: `cpu_en` drops asynchronously; all state returns to reset values.
- Edge to `cpu_en`:
  - `run_req` sampled at edge N gives `cpu_en`=1 during cycle N+1.
  - A step edge sampled at N gives `cpu_en`=1 for cycles N+1..N+`STEP_CYCLES`; `step_done` comes at cycle N+`STEP_CYCLES`+1.
- `bp_hit` is asserted in the cycle after the edge that transitions RUN→HALT.
- Debug read latency: 1 cycle from acceptance to `dbg_rd_valid`.

## Configuration
- `CPU_RUN_CTRL_BP_EN` defined: breakpoint logic (`bp_match`, `bp_armed`, `bp_hit`) is compiled in.
- Undefined: `bp_match`≡0 and `bp_hit` is tied to 0. `bp_valid`, `bp_addr` and `pc_if` are unused; RUN exits only via `halt_req` or `run_req`=0.

## Test plan
- Reset then `run_req`=1 for 10 cycles, then 0 → `cpu_en` high for exactly 10 cycles, `cycle_cnt`=10, `halted`=1 afterwards.
- `STEP_CYCLES`=1, three `step_req` pulses from HALT → three `step_done` pulses, `cycle_cnt`=3, `cpu_en` never high for 2 consecutive cycles.
- BP_EN defined, `bp_addr`=0x0000000C, PC counting by 4 from 0 with `run_req` held → `bp_hit` once, `cpu_en`=0 while `pc_if`=0x0C. Toggle `run_req` 0→1 → core advances past 0x0C with no second hit.
- Halted, `rf_rd_data`=0xDEADBEEF for index 5, `dbg_rd_req`=1 with `dbg_rd_idx`=5 for one cycle → `rf_rd_idx`=5; next cycle `dbg_rd_valid`=1 with `dbg_rd_data`=0xDEADBEEF.
- Request during RUN → no valid until `run_req`=0 and HALT is reached, then valid 2 cycles later.
- Assert `reset` low mid-STEP (`STEP_CYCLES`=4, cycle 2) → `cpu_en`=0 immediately, no `step_done`, `cycle_cnt`=0.
